// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply controller.
// Holds the multiplier handshake levels, FSM state type and the zero word.
package mul_hilo_ctrl_pkg;

  localparam logic MUL_START = 1'b1;
  localparam logic MUL_STOP  = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    HILO_IDLE  = 2'b00,
    HILO_BUSY  = 2'b01,
    HILO_DRAIN = 2'b10
  } hilo_state_t;

  function automatic logic [31:0] mf_select(input logic i_mfhi, input logic i_mflo,
                                            input logic [31:0] i_hi, input logic [31:0] i_lo);
    logic [31:0] r;
    r = ZERO_WORD;
    if (i_mfhi)      r = i_hi;
    else if (i_mflo) r = i_lo;
    return r;
  endfunction

endpackage

// File: rtl/mul_hilo_ctrl_if.sv
// Handshake bus between the EX-stage controller and the iterative multiplier.
interface mul_hilo_ctrl_if;
  logic        start;
  logic        annul;
  logic        signed_mul;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [63:0] result;
  logic        ready;

  modport master (
    output start, annul, signed_mul, op1, op2,
    input  result, ready
  );

  modport slave (
    input  start, annul, signed_mul, op1, op2,
    output result, ready
  );
endinterface

// File: rtl/mul_hilo_ctrl_hilo_reg.sv
// Architectural HI/LO register pair with independent write enables.
module hilo_reg #(
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hi_we,
  input  logic [31:0] i_hi_d,
  input  logic        i_lo_we,
  input  logic [31:0] i_lo_d,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= RST_VAL;
      r_lo <= RST_VAL;
    end else begin
      if (i_hi_we) r_hi <= i_hi_d;
      if (i_lo_we) r_lo <= i_lo_d;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// EX-stage issue/commit controller for the iterative multiplier and HI/LO pair.
// Launches MULT/MULTU, stalls until the product returns, drains the multiplier after a flush.
import mul_hilo_ctrl_pkg::*;

module mul_hilo_ctrl #(
  parameter logic [31:0] HILO_RST     = 32'h0,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_op_mult,
  input  logic                  i_op_multu,
  input  logic                  i_op_mthi,
  input  logic                  i_op_mtlo,
  input  logic                  i_op_mfhi,
  input  logic                  i_op_mflo,
  input  logic [31:0]           i_rs_data,
  input  logic [31:0]           i_rt_data,
  mul_hilo_ctrl_if.master       mul_bus,
  output logic                  o_stall_req,
  output logic [31:0]           o_mf_data,
  output logic [31:0]           o_hi,
  output logic [31:0]           o_lo
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

  hilo_state_t      r_state;
  hilo_state_t      w_next;
  logic [31:0]      r_op1;
  logic [31:0]      r_op2;
  logic             r_signed;
  logic [CNT_W-1:0] r_cnt;

  logic             w_mul_req;
  logic             w_latch;
  logic             w_cnt_load;
  logic             w_hi_we;
  logic             w_lo_we;
  logic [31:0]      w_hi_d;
  logic [31:0]      w_lo_d;

  assign w_mul_req = i_op_mult | i_op_multu;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= HILO_IDLE;
      r_op1    <= ZERO_WORD;
      r_op2    <= ZERO_WORD;
      r_signed <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_op1    <= i_rs_data;
        r_op2    <= i_rt_data;
        r_signed <= i_op_mult;
      end
      if (w_cnt_load)
        r_cnt <= CNT_W'(DRAIN_CYCLES);
      else if (r_state == HILO_DRAIN && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_next             = r_state;
    w_latch            = 1'b0;
    w_cnt_load         = 1'b0;
    w_hi_we            = 1'b0;
    w_lo_we            = 1'b0;
    w_hi_d             = ZERO_WORD;
    w_lo_d             = ZERO_WORD;
    o_stall_req        = 1'b0;
    mul_bus.start      = MUL_STOP;
    mul_bus.annul      = 1'b0;
    mul_bus.signed_mul = r_signed;
    mul_bus.op1        = r_op1;
    mul_bus.op2        = r_op2;

    unique case (r_state)
      HILO_IDLE: begin
        if (!i_flush) begin
          if (w_mul_req) begin
            // Operands bypass the latches in the launch cycle so the multiplier sees them at once.
            w_latch            = 1'b1;
            mul_bus.start      = MUL_START;
            mul_bus.signed_mul = i_op_mult;
            mul_bus.op1        = i_rs_data;
            mul_bus.op2        = i_rt_data;
            o_stall_req        = 1'b1;
            w_next             = HILO_BUSY;
          end else if (i_op_mthi) begin
            w_hi_we = 1'b1;
            w_hi_d  = i_rs_data;
          end else if (i_op_mtlo) begin
            w_lo_we = 1'b1;
            w_lo_d  = i_rs_data;
          end
        end
      end

      HILO_BUSY: begin
        if (i_flush) begin
          mul_bus.annul = 1'b1;
          w_cnt_load    = 1'b1;
          w_next        = HILO_DRAIN;
        end else if (mul_bus.ready) begin
          w_hi_we = 1'b1;
          w_lo_we = 1'b1;
          w_hi_d  = mul_bus.result[63:32];
          w_lo_d  = mul_bus.result[31:0];
          w_next  = HILO_IDLE;
        end else begin
          mul_bus.start = MUL_START;
          o_stall_req   = 1'b1;
        end
      end

      HILO_DRAIN: begin
        // A multiply waiting here is held in EX; it is latched only once back in IDLE.
        if (w_mul_req && !i_flush) o_stall_req = 1'b1;
        if (r_cnt <= CNT_W'(1)) w_next = HILO_IDLE;
      end

      default: w_next = HILO_IDLE;
    endcase
  end

  hilo_reg #(
    .RST_VAL (HILO_RST)
  ) u_hilo_reg (
    .clk     (clk),
    .rst     (rst),
    .i_hi_we (w_hi_we),
    .i_hi_d  (w_hi_d),
    .i_lo_we (w_lo_we),
    .i_lo_d  (w_lo_d),
    .o_hi    (o_hi),
    .o_lo    (o_lo)
  );

  assign o_mf_data = mf_select(i_op_mfhi, i_op_mflo, o_hi, o_lo);

endmodule
